// File: rtl/run_decoding.sv
// run_decoding: CAVLC run/placement stage; places decoded levels at their scan
// positions using total_zeros and the run_before stream, then pulses done.
module run_decoding #(
    parameter int LW = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       TotalCoeff,
    input  logic [3:0]       total_zeros,
    input  logic [4:0]       max_num_coeff,
    input  logic [16*LW-1:0] levels,
    input  logic             run_valid,
    input  logic [3:0]       run_before,
    output logic             run_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [16*LW-1:0] coeffs
);
    typedef enum logic [1:0] {IDLE, PLACE, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] tc, pos;
    logic [3:0] i, zl, rr, r, idx;
    logic [5:0] span;
    logic off, need_run, last, clamp, step, accept, bad;
    always_comb begin
        last     = {1'b0, i} == tc - 5'd1;
        need_run = ({1'b0, i} < tc - 5'd1) && (zl != 4'd0);
        step     = (state == PLACE) && !(need_run && !run_valid);
        rr       = need_run ? run_before : 4'd0;
        clamp    = rr > zl;
        r        = clamp ? zl : rr;
        idx      = pos[3:0] + {3'b0, off};
        span     = {1'b0, TotalCoeff} + {2'b0, total_zeros};
        accept   = (state == IDLE) && start;
        bad      = (TotalCoeff != 5'd0) && (span > {1'b0, max_num_coeff});
        state_nx = accept ? ((TotalCoeff == 5'd0 || bad) ? DONE : PLACE) :
                   (step && last) ? DONE :
                   (state == DONE) ? IDLE : state;
        run_ready = (state == PLACE) && need_run;
        busy      = state != IDLE;
        done      = state == DONE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            tc     <= '0;
            off    <= 1'b0;
            i      <= '0;
            pos    <= '0;
            zl     <= '0;
            coeffs <= '0;
            error  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                coeffs <= '0;
                error  <= bad;
                tc     <= TotalCoeff;
                off    <= max_num_coeff == 5'd15;
                zl     <= total_zeros;
                pos    <= TotalCoeff - 5'd1 + {1'b0, total_zeros};
                i      <= '0;
            end else if (step) begin
                // a run larger than the remaining zeros is clamped so pos cannot underflow
                coeffs[idx*LW +: LW] <= levels[i*LW +: LW];
                pos <= pos - {1'b0, r} - 5'd1;
                zl  <= zl - r;
                i   <= i + 4'd1;
                if (clamp) error <= 1'b1;
            end
        end
    end
endmodule
